// File: rtl/rom_arbiter_if.sv
// Requester-side bus of the shared image ROM port: request/address in, grant and tagged read data out.
interface rom_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 12
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]        gnt;
   logic [DATA_W-1:0]         rd_data;
   logic [NUM_REQ-1:0]        rd_valid;

   modport master (output req, req_addr, input gnt, rd_data, rd_valid);
   modport slave  (input req, req_addr, output gnt, rd_data, rd_valid);
endinterface

// File: rtl/rom_arbiter.sv
// Shares one image ROM read port between NUM_REQ pixel requesters: fixed priority for
// requester 0 (optional) plus round robin, one read per cycle, data returned with a one-hot owner tag.
module rom_arbiter #(
   parameter int NUM_REQ     = 3,
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 12,
   parameter int ROM_LATENCY = 0,
   parameter bit PRIO0       = 1'b1
) (
   input  logic              pclk,
   input  logic              rst,
   rom_arbiter_if.slave      bus,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int DEPTH = 1 + ROM_LATENCY;

   logic [IDX_W-1:0]   ptr_q;
   logic [IDX_W-1:0]   win_idx;
   logic               win_any;
   logic               win_rr;
   logic [ADDR_W-1:0]  win_addr;
   int                 idx;

   logic               vld_pipe [DEPTH];
   logic [NUM_REQ-1:0] id_pipe  [DEPTH];

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      win_idx = '0;
      win_any = 1'b0;
      win_rr  = 1'b0;
      idx     = 0;
      if (rst) begin
         if (PRIO0 && bus.req[0]) begin
            win_any = 1'b1;
         end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
               idx = (int'(ptr_q) + k) % NUM_REQ;
               if (!win_any && bus.req[IDX_W'(idx)] && !(PRIO0 && idx == 0)) begin
                  win_any = 1'b1;
                  win_rr  = 1'b1;
                  win_idx = IDX_W'(idx);
               end
            end
         end
      end
   end

   assign bus.gnt  = win_any ? (NUM_REQ'(1) << win_idx) : '0;
   assign win_addr = bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge pclk) begin
      if (!rst) begin
         ptr_q        <= IDX_W'(NUM_REQ - 1);
         rom_addr     <= '0;
         bus.rd_data  <= '0;
         bus.rd_valid <= '0;
         // NOTE: the tag pipeline is reset too, so reads in flight at reset never surface afterwards.
         for (int i = 0; i < DEPTH; i++) begin
            vld_pipe[i] <= 1'b0;
            id_pipe[i]  <= '0;
         end
      end else begin
         if (win_rr)  ptr_q    <= win_idx;
         if (win_any) rom_addr <= win_addr;

         vld_pipe[0] <= win_any;
         id_pipe[0]  <= bus.gnt;
         for (int i = 1; i < DEPTH; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            id_pipe[i]  <= id_pipe[i-1];
         end

         // The tag reaches the end of the pipe exactly when rom_data holds that read's word.
         if (vld_pipe[DEPTH-1]) begin
            bus.rd_data  <= rom_data;
            bus.rd_valid <= id_pipe[DEPTH-1];
         end else begin
            bus.rd_valid <= '0;
         end
      end
   end
endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: three instances (PRIO0=1, PRIO0=0, ROM_LATENCY=2) with
// hand-written grant sequences and a small delayed-return scoreboard for rd_valid/rd_data.
module tb_rom_arbiter;
   localparam int N  = 3;
   localparam int AW = 12;
   localparam int DW = 12;

   logic pclk = 1'b0;
   logic rst  = 1'b0;
   always #5 pclk = ~pclk;

   int errors = 0;
   int checks = 0;

   function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
      return {a[3:0], a[11:4]} ^ 12'h5A3;
   endfunction

   rom_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) if_a ();
   rom_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) if_b ();
   rom_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) if_c ();

   logic [N-1:0]    req_v  [3];
   logic [N*AW-1:0] addr_v [3];
   logic [AW-1:0]   rom_addr_v [3];
   logic [DW-1:0]   rom_data_a, rom_data_b, rom_data_c;
   logic [DW-1:0]   rom_q1, rom_q2;

   assign if_a.req = req_v[0];  assign if_a.req_addr = addr_v[0];
   assign if_b.req = req_v[1];  assign if_b.req_addr = addr_v[1];
   assign if_c.req = req_v[2];  assign if_c.req_addr = addr_v[2];

   assign rom_data_a = rom_f(rom_addr_v[0]);
   assign rom_data_b = rom_f(rom_addr_v[1]);
   always @(posedge pclk) begin
      rom_q1 <= rom_f(rom_addr_v[2]);
      rom_q2 <= rom_q1;
   end
   assign rom_data_c = rom_q2;

   rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(0), .PRIO0(1'b1)) u_a (
      .pclk(pclk), .rst(rst), .bus(if_a.slave), .rom_addr(rom_addr_v[0]), .rom_data(rom_data_a));
   rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(0), .PRIO0(1'b0)) u_b (
      .pclk(pclk), .rst(rst), .bus(if_b.slave), .rom_addr(rom_addr_v[1]), .rom_data(rom_data_b));
   rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(2), .PRIO0(1'b1)) u_c (
      .pclk(pclk), .rst(rst), .bus(if_c.slave), .rom_addr(rom_addr_v[2]), .rom_data(rom_data_c));

   logic [N-1:0]  obs_gnt  [3];
   logic [N-1:0]  obs_vld  [3];
   logic [DW-1:0] obs_data [3];
   assign obs_gnt[0] = if_a.gnt;  assign obs_vld[0] = if_a.rd_valid;  assign obs_data[0] = if_a.rd_data;
   assign obs_gnt[1] = if_b.gnt;  assign obs_vld[1] = if_b.rd_valid;  assign obs_data[1] = if_b.rd_data;
   assign obs_gnt[2] = if_c.gnt;  assign obs_vld[2] = if_c.rd_valid;  assign obs_data[2] = if_c.rd_data;

   // Expected returns: slot k holds what rd_valid/rd_data must show k cycles from now.
   logic [N-1:0]  fut_v [3][8];
   logic [DW-1:0] fut_d [3][8];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle on instance d: drive just after the edge, check mid-cycle, then update the model.
   task automatic run_cycle(input int d, input logic rn, input logic [N-1:0] r,
                            input logic [N*AW-1:0] a, input logic [N-1:0] eg, input string tag);
      int lat;
      int w;
      lat = (d == 2) ? 2 : 0;
      @(posedge pclk);
      #1;
      rst = rn;
      for (int dd = 0; dd < 3; dd++) begin
         req_v[dd] = (dd == d) ? r : '0;
         if (dd == d) addr_v[dd] = a;
      end
      #3;
      check({tag, " gnt"}, 32'(obs_gnt[d]), 32'(eg));
      check({tag, " rd_valid"}, 32'(obs_vld[d]), 32'(fut_v[d][0]));
      if (fut_v[d][0] != '0) check({tag, " rd_data"}, 32'(obs_data[d]), 32'(fut_d[d][0]));
      if (eg != '0) begin
         w = 0;
         for (int i = 0; i < N; i++) if (eg[i]) w = i;
         fut_v[d][2+lat] = eg;
         fut_d[d][2+lat] = rom_f(a[w*AW +: AW]);
      end
      for (int k = 0; k < 7; k++) begin
         fut_v[d][k] = fut_v[d][k+1];
         fut_d[d][k] = fut_d[d][k+1];
      end
      fut_v[d][7] = '0;
      fut_d[d][7] = '0;
      if (!rn) begin
         for (int dd = 0; dd < 3; dd++)
            for (int k = 0; k < 8; k++) begin
               fut_v[dd][k] = '0;
               fut_d[dd][k] = '0;
            end
      end
   endtask

   task automatic do_reset(input int d);
      for (int i = 0; i < 3; i++) run_cycle(d, 1'b0, 3'b111, {12'hFFF, 12'hEEE, 12'hDDD}, 3'b000, "reset");
      check("reset rom_addr", 32'(rom_addr_v[d]), 32'h0);
      check("reset rd_data", 32'(obs_data[d]), 32'h0);
   endtask

   localparam logic [N*AW-1:0] ADDR_T1 = {12'h000, 12'h123, 12'h000};
   localparam logic [N*AW-1:0] ADDR_RR = {12'h222, 12'h111, 12'h0AA};
   localparam logic [N*AW-1:0] ADDR_B  = {12'h0C3, 12'h0B2, 12'h0A1};

   initial begin
      for (int dd = 0; dd < 3; dd++) begin
         req_v[dd]  = '0;
         addr_v[dd] = '0;
         for (int k = 0; k < 8; k++) begin
            fut_v[dd][k] = '0;
            fut_d[dd][k] = '0;
         end
      end

      // 1: single requester after reset
      do_reset(0);
      run_cycle(0, 1'b1, 3'b010, ADDR_T1, 3'b010, "t1 c0");
      run_cycle(0, 1'b1, 3'b000, ADDR_T1, 3'b000, "t1 c1");
      check("t1 rom_addr", 32'(rom_addr_v[0]), 32'h123);
      run_cycle(0, 1'b1, 3'b000, ADDR_T1, 3'b000, "t1 c2");
      run_cycle(0, 1'b1, 3'b000, ADDR_T1, 3'b000, "t1 c3");
      check("t1 rd_data hold", 32'(obs_data[0]), 32'(rom_f(12'h123)));

      // 2: requester 0 has absolute priority
      do_reset(0);
      for (int i = 0; i < 4; i++) run_cycle(0, 1'b1, 3'b111, ADDR_RR, 3'b001, "t2 prio");
      for (int i = 0; i < 2; i++) run_cycle(0, 1'b1, 3'b000, ADDR_RR, 3'b000, "t2 drain");

      // 3: round robin over 1..2, then requester 0 preempts without moving the pointer
      do_reset(0);
      run_cycle(0, 1'b1, 3'b110, ADDR_RR, 3'b010, "t3 rr0");
      run_cycle(0, 1'b1, 3'b110, ADDR_RR, 3'b100, "t3 rr1");
      run_cycle(0, 1'b1, 3'b110, ADDR_RR, 3'b010, "t3 rr2");
      run_cycle(0, 1'b1, 3'b110, ADDR_RR, 3'b100, "t3 rr3");
      run_cycle(0, 1'b1, 3'b110, ADDR_RR, 3'b010, "t3 rr4");
      run_cycle(0, 1'b1, 3'b111, ADDR_RR, 3'b001, "t3 pre");
      run_cycle(0, 1'b1, 3'b110, ADDR_RR, 3'b100, "t3 rr5");
      for (int i = 0; i < 2; i++) run_cycle(0, 1'b1, 3'b000, ADDR_RR, 3'b000, "t3 drain");

      // 4: PRIO0=0, full round robin with wrap to index 0
      do_reset(1);
      for (int i = 0; i < 6; i++)
         run_cycle(1, 1'b1, 3'b111, ADDR_B, 3'(1 << (i % 3)), "t4 rr");
      for (int i = 0; i < 2; i++) run_cycle(1, 1'b1, 3'b000, ADDR_B, 3'b000, "t4 drain");

      // 5: ROM_LATENCY=2, back-to-back reads from requester 2
      do_reset(2);
      run_cycle(2, 1'b1, 3'b100, {12'h010, 24'h0}, 3'b100, "t5 b0");
      run_cycle(2, 1'b1, 3'b100, {12'h011, 24'h0}, 3'b100, "t5 b1");
      run_cycle(2, 1'b1, 3'b100, {12'h012, 24'h0}, 3'b100, "t5 b2");
      for (int i = 0; i < 5; i++) run_cycle(2, 1'b1, 3'b000, {12'h012, 24'h0}, 3'b000, "t5 drain");

      // 6: reset while a read is in flight
      do_reset(0);
      run_cycle(0, 1'b1, 3'b010, {12'h000, 12'h3C3, 12'h000}, 3'b010, "t6 grant");
      run_cycle(0, 1'b0, 3'b000, ADDR_RR, 3'b000, "t6 rst");
      for (int i = 0; i < 4; i++) begin
         run_cycle(0, 1'b1, 3'b000, ADDR_RR, 3'b000, "t6 quiet");
         check("t6 rd_data", 32'(obs_data[0]), 32'h0);
      end
      run_cycle(0, 1'b1, 3'b110, ADDR_RR, 3'b010, "t6 ptr");
      for (int i = 0; i < 2; i++) run_cycle(0, 1'b1, 3'b000, ADDR_RR, 3'b000, "t6 drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
